// File: rtl/cyber_pkg.sv
// Shared types and constants for the CyberWar computer-opponent button transmitter.
package cyber_pkg;
  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'h001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    RELEASE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;
endpackage

// File: rtl/lfsr_async10.sv
// 10-bit Fibonacci LFSR (taps 9,6) with async active-low reset and zero-lockup reload.
module lfsr_async10
  import cyber_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= SEED;
    end else if (en) begin
      // All-zero is a lockup state for this feedback; recover by reseeding.
      if (value == '0) value <= SEED;
      else             value <= {value[LFSR_W-2:0], value[TAP_HI] ^ value[TAP_LO]};
    end
  end

endmodule

// File: rtl/cyber_press_gen.sv
// Computer-opponent button-press generator: LFSR-vs-difficulty press decisions with
// guaranteed hold/gap times and a post-round cooldown.
module cyber_press_gen
  import cyber_pkg::*;
#(
  parameter int                HOLD_CYCLES     = 4,
  parameter int                GAP_CYCLES      = 4,
  parameter int                COOLDOWN_CYCLES = 16,
  parameter logic [LFSR_W-1:0] SEED            = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] difficulty,
  input  logic              round_end,
  output logic              press,
  output logic              busy,
  output logic [7:0]        press_count
);

  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > COOLDOWN_CYCLES) ? CNT_MAX_HG : COOLDOWN_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        count_d;

  lfsr_async10 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .value (lfsr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = press_count;
    // round_end overrides everything, aborting any press in flight.
    if (round_end) begin
      state_d = COOLDOWN;
      cnt_d   = COOL_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && (lfsr < difficulty)) begin
            state_d = PRESS;
            cnt_d   = HOLD_LOAD;
            count_d = press_count + 8'd1;
          end
        end
        PRESS: begin
          if (cnt_q == '0) begin
            state_d = RELEASE;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RELEASE, COOLDOWN: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      press       <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press       <= (state_d == PRESS);
      press_count <= count_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cyber_press_gen.sv
// Scoreboard bench for cyber_press_gen: timeline-based reference model feeds a queue
// that an independent monitor drains one entry per clock.
module tb_cyber_press_gen;
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int COOL = 16;
  localparam logic [9:0] SEED = 10'h001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] difficulty = '0;
  logic       round_end = 1'b0;
  logic       press, busy;
  logic [7:0] press_count;

  cyber_press_gen #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .COOLDOWN_CYCLES(COOL), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .difficulty(difficulty),
    .round_end(round_end), .press(press), .busy(busy), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       press;
    logic       busy;
    logic [7:0] count;
    logic [9:0] lfsr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: absolute-cycle timeline rather than a state machine.
  int m_n, m_idle_at, m_p_first, m_p_last, m_count, m_total;
  int m_lfsr;

  function automatic int lfsr_next(input int v);
    int fb;
    if (v == 0) return int'(SEED);
    fb = ((v >> 9) & 1) ^ ((v >> 6) & 1);
    return ((v * 2) % 1024) + fb;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_idle_at = 0; m_p_first = 1; m_p_last = 0;
    m_count = 0; m_total = 0; m_lfsr = int'(SEED);
  endtask

  // Drive one cycle of inputs and push what the DUT must show after the next edge.
  task automatic step(input logic en, input logic [9:0] diff, input logic re);
    exp_t e;
    @(negedge clk);
    enable = en; difficulty = diff; round_end = re;
    if (re) begin
      m_idle_at = m_n + 1 + COOL;
      m_p_last  = m_n;
    end else if (m_n >= m_idle_at && en && (m_lfsr < int'(diff))) begin
      m_p_first = m_n + 1;
      m_p_last  = m_n + HOLD;
      m_idle_at = m_n + 1 + HOLD + GAP;
      m_count   = (m_count + 1) % 256;
      m_total++;
    end
    e.press = (m_n + 1 >= m_p_first) && (m_n + 1 <= m_p_last);
    e.busy  = (m_n + 1 < m_idle_at);
    e.count = 8'(m_count);
    m_lfsr  = lfsr_next(m_lfsr);
    e.lfsr  = 10'(m_lfsr);
    exp_q.push_back(e);
    m_n++;
  endtask

  // Assert reset between edges; optionally verify the asynchronous clear at once.
  task automatic do_reset(input bit chk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    if (chk) begin
      check("reset_press", press, 0);
      check("reset_busy", busy, 0);
      check("reset_count", press_count, 0);
      check("reset_lfsr", dut.lfsr, int'(SEED));
    end
    exp_q.delete();
    round_end = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("press", press, e.press);
        check("busy", busy, e.busy);
        check("press_count", press_count, e.count);
        check("lfsr", dut.lfsr, e.lfsr);
      end
    end
  end

  initial begin : stimulus
    int guard;
    model_reset();
    #23;
    do_reset(1'b1);

    // LFSR free-run with the opponent disabled
    for (int i = 0; i < 12; i++) step(1'b0, 10'($urandom_range(0, 1023)), 1'b0);

    // Easy difficulty from reset release: first IDLE cycle presses
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 10'h005, 1'b0);

    // Maximum difficulty for 90 cycles
    do_reset(1'b0);
    for (int i = 0; i < 90; i++) step(1'b1, 10'h3FF, 1'b0);

    // difficulty 0 never presses
    for (int i = 0; i < 30; i++) step(1'b1, 10'h000, 1'b0);

    // round_end in the second PRESS cycle
    do_reset(1'b0);
    step(1'b1, 10'h3FF, 1'b0);
    step(1'b1, 10'h3FF, 1'b0);
    step(1'b1, 10'h3FF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 10'h3FF, 1'b0);
    step(1'b1, 10'h3FF, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 10'h3FF, 1'b0);

    // enable dropped in the first PRESS cycle
    do_reset(1'b0);
    step(1'b1, 10'h005, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 10'h3FF, 1'b0);

    // Randomised mix of enable, difficulty and round_end
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
           1'($urandom_range(0, 49) == 0));

    // Force enough presses to wrap press_count
    do_reset(1'b0);
    guard = 0;
    while (m_total < 257 && guard < 4000) begin
      step(1'b1, 10'h3FF, 1'b0);
      guard++;
    end
    tests++;
    if (m_total < 257) begin
      fails++;
      $display("FAIL wrap_budget: presses %0d required 257", m_total);
    end
    // Reset while press is high
    guard = 0;
    while (!(m_n >= m_p_first && m_n <= m_p_last - 1) && guard < 20) begin
      step(1'b1, 10'h3FF, 1'b0);
      guard++;
    end
    @(posedge clk); #2;
    check("mid_press_high", press, 1);
    reset = 1'b0;
    #1;
    check("mid_reset_press", press, 0);
    check("mid_reset_lfsr", dut.lfsr, int'(SEED));
    check("mid_reset_count", press_count, 0);
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 10'h3FF, 1'b0);

    @(posedge clk); @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
